// File: rtl/ctrl_reg_bank.sv
// Byte-addressed configuration register bank with shadow/active copies,
// key-based unlock, atomic commit/discard and idle auto-relock.
module ctrl_reg_bank #(
  parameter int                AW      = 22,
  parameter int                NREG    = 16,
  parameter logic [AW-1:0]     BASE    = AW'('h100),
  parameter logic [NREG*8-1:0] RST_VAL = '0,
  parameter int                LOCK_TO = 65535,
  parameter logic [7:0]        VERSION = 8'h21
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [AW-1:0]     fx_waddr,
  input  logic              fx_wr,
  input  logic [7:0]        fx_data,
  input  logic              fx_rd,
  input  logic [AW-1:0]     fx_raddr,
  output logic [7:0]        fx_q,
  output logic [NREG*8-1:0] cfg_out,
  output logic              cfg_upd,
  output logic              cfg_unlocked
);

  localparam int            NOFF     = 2*NREG + 4;
  localparam int            OW       = 8;
  localparam logic [OW-1:0] OFF_CTRL = OW'(NREG);
  localparam logic [OW-1:0] OFF_KEY  = OW'(NREG + 1);
  localparam logic [OW-1:0] OFF_STAT = OW'(NREG + 2);
  localparam logic [OW-1:0] OFF_ID   = OW'(NREG + 3);
  localparam logic [7:0]    KEY_VAL  = 8'hA5;
  localparam logic [15:0]   IDLE_MAX = 16'(LOCK_TO - 1);

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_COMMIT} state_e;

  state_e               state_q, state_d;
  logic [NREG-1:0][7:0] shadow_q, shadow_d;
  logic [NREG-1:0][7:0] active_q, active_d;
  logic [15:0]          idle_q, idle_d;
  logic                 err_q, err_d;
  logic                 upd_q, upd_d;
  logic [7:0]           rdata_q, rdata_d;

  logic [AW:0]   woff, roff;
  logic [OW-1:0] wsel, rsel;
  logic          w_hit, r_hit;
  logic          w_sh, w_ctrl, w_key, can_wr, err_set, st_rd;
  logic          pending, unlocked;
  logic [7:0]    rd_val;

  // One extra bit so addresses below BASE wrap to a huge offset and miss.
  assign woff  = {1'b0, fx_waddr} - {1'b0, BASE};
  assign roff  = {1'b0, fx_raddr} - {1'b0, BASE};
  assign w_hit = fx_wr && (woff < (AW+1)'(NOFF));
  assign r_hit = fx_rd && (roff < (AW+1)'(NOFF));
  assign wsel  = woff[OW-1:0];
  assign rsel  = roff[OW-1:0];

  assign w_sh     = w_hit && (wsel < OW'(NREG));
  assign w_ctrl   = w_hit && (wsel == OFF_CTRL);
  assign w_key    = w_hit && (wsel == OFF_KEY);
  assign st_rd    = r_hit && (rsel == OFF_STAT);
  assign can_wr   = (state_q != S_LOCKED);
  assign pending  = (shadow_q != active_q);
  assign unlocked = (state_q == S_UNLOCKED);

  always_comb begin
    rd_val = 8'h00;
    if (r_hit) begin
      if (rsel == OFF_STAT)    rd_val = {5'b0, err_q, pending, unlocked};
      else if (rsel == OFF_ID) rd_val = VERSION;
      for (int i = 0; i < NREG; i++) begin
        if (rsel == OW'(i))          rd_val = shadow_q[i];
        if (rsel == OW'(NREG + 4 + i)) rd_val = active_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    idle_d   = idle_q;
    rdata_d  = rdata_q;
    upd_d    = (state_q == S_COMMIT);
    err_set  = 1'b0;

    // Copy happens first so a write landing in the commit cycle stays uncommitted.
    if (state_q == S_COMMIT) begin
      active_d = shadow_q;
      state_d  = S_UNLOCKED;
    end

    if (w_sh) begin
      if (can_wr) begin
        for (int i = 0; i < NREG; i++)
          if (wsel == OW'(i)) shadow_d[i] = fx_data;
      end else begin
        err_set = 1'b1;
      end
    end

    if (w_ctrl) begin
      if (!can_wr)         err_set  = 1'b1;
      else if (fx_data[0]) state_d  = S_COMMIT;
      else if (fx_data[1]) shadow_d = active_d;
    end

    if (w_key) state_d = (fx_data == KEY_VAL) ? S_UNLOCKED : S_LOCKED;

    if (state_q == S_UNLOCKED) begin
      if (w_sh || w_ctrl || w_key) begin
        idle_d = '0;
      end else if (idle_q == IDLE_MAX) begin
        idle_d  = '0;
        state_d = S_LOCKED;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end else begin
      idle_d = '0;
    end

    if (fx_rd) rdata_d = rd_val;
    err_d = (err_q & ~st_rd) | err_set;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOCKED;
      shadow_q <= RST_VAL;
      active_q <= RST_VAL;
      idle_q   <= '0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign fx_q         = rdata_q;
  assign cfg_out      = active_q;
  assign cfg_upd      = upd_q;
  assign cfg_unlocked = unlocked;

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Directed bench for ctrl_reg_bank: a transaction-level register model is
// compared every cycle, plus literal checks on the key scenarios.
module tb_ctrl_reg_bank;

  localparam int AW      = 22;
  localparam int NREG    = 16;
  localparam int LOCK_TO = 8;
  localparam int BASE    = 'h100;
  localparam int W       = NREG * 8;

  logic            clk_sys = 1'b0;
  logic            rst_n   = 1'b1;
  logic [AW-1:0]   fx_waddr = '0;
  logic            fx_wr    = 1'b0;
  logic [7:0]      fx_data  = '0;
  logic            fx_rd    = 1'b0;
  logic [AW-1:0]   fx_raddr = '0;
  logic [7:0]      fx_q;
  logic [W-1:0]    cfg_out;
  logic            cfg_upd;
  logic            cfg_unlocked;

  ctrl_reg_bank #(.AW(AW), .NREG(NREG), .BASE(22'h000100), .LOCK_TO(LOCK_TO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .fx_waddr(fx_waddr), .fx_wr(fx_wr),
    .fx_data(fx_data), .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .cfg_out(cfg_out), .cfg_upd(cfg_upd), .cfg_unlocked(cfg_unlocked)
  );

  always #5 clk_sys = ~clk_sys;

  int nvec = 0;
  int nmiss = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- register model ----------------
  logic [7:0] m_sh[NREG];
  logic [7:0] m_ac[NREG];
  bit         m_unl, m_commit, m_err, m_upd;
  int         m_idle;
  logic [7:0] m_q;

  function automatic void m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_sh[i] = 8'h00;
      m_ac[i] = 8'h00;
    end
    m_unl = 0; m_commit = 0; m_err = 0; m_upd = 0; m_idle = 0; m_q = 8'h00;
  endfunction

  function automatic logic [7:0] m_read(input int off);
    bit pend = 0;
    for (int i = 0; i < NREG; i++) if (m_sh[i] != m_ac[i]) pend = 1;
    if (off >= 0 && off < NREG)              return m_sh[off];
    if (off == NREG + 2)                     return {5'b0, m_err, pend, m_unl};
    if (off == NREG + 3)                     return 8'h21;
    if (off >= NREG + 4 && off < 2*NREG + 4) return m_ac[off - NREG - 4];
    return 8'h00;
  endfunction

  function automatic void m_step(input logic wr, input logic [AW-1:0] wa, input logic [7:0] wd,
                                 input logic rd, input logic [AW-1:0] ra);
    int wo = int'(wa) - BASE;
    int ro = int'(ra) - BASE;
    bit was_unl = m_unl;
    bit eset = 0, wrote = 0;
    logic [7:0] rv = m_read(ro);
    m_upd = m_commit;
    if (m_commit) begin
      for (int i = 0; i < NREG; i++) m_ac[i] = m_sh[i];
      m_commit = 0;
      m_unl = 1;
    end
    if (wr) begin
      if (wo >= 0 && wo < NREG) begin
        if (m_unl) begin m_sh[wo] = wd; wrote = 1; end
        else eset = 1;
      end else if (wo == NREG) begin
        if (!m_unl) eset = 1;
        else begin
          wrote = 1;
          if (wd[0]) begin m_commit = 1; m_unl = 0; end
          else if (wd[1]) for (int i = 0; i < NREG; i++) m_sh[i] = m_ac[i];
        end
      end else if (wo == NREG + 1) begin
        wrote = 1;
        m_unl = (wd == 8'hA5);
        m_commit = 0;
      end
    end
    if (was_unl) begin
      if (wrote) m_idle = 0;
      else if (m_idle == LOCK_TO - 1) begin m_idle = 0; m_unl = 0; end
      else m_idle++;
    end else m_idle = 0;
    if (rd) m_q = rv;
    m_err = (m_err && !(rd && ro == NREG + 2)) || eset;
  endfunction

  // Per-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge clk_sys) begin
    logic [W-1:0] exp_cfg;
    #1;
    if (!rst_n) m_reset();
    else m_step(fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr);
    for (int i = 0; i < NREG; i++) exp_cfg[i*8 +: 8] = m_ac[i];
    check("model fx_q", W'(fx_q), W'(m_q));
    check("model cfg_out", cfg_out, exp_cfg);
    check("model cfg_upd", W'(cfg_upd), W'(m_upd));
    check("model cfg_unlocked", W'(cfg_unlocked), W'(m_unl));
  end

  // ---------------- stimulus helpers (entered and left at a negedge) ----------------
  task automatic wra(input logic [AW-1:0] a, input logic [7:0] d);
    fx_wr = 1'b1; fx_waddr = a; fx_data = d;
    @(negedge clk_sys);
    fx_wr = 1'b0;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    wra(AW'(BASE + off), d);
  endtask

  task automatic rda(input logic [AW-1:0] a, output logic [7:0] v);
    fx_rd = 1'b1; fx_raddr = a;
    @(negedge clk_sys);
    fx_rd = 1'b0;
    v = fx_q;
  endtask

  task automatic rd(input int off, output logic [7:0] v);
    rda(AW'(BASE + off), v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  localparam int CTRL = NREG;
  localparam int KEY  = NREG + 1;
  localparam int STAT = NREG + 2;
  localparam int ID   = NREG + 3;
  localparam int ACT0 = NREG + 4;

  initial begin
    logic [7:0] v;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    check("reset cfg_out", cfg_out, '0);
    check("reset fx_q", W'(fx_q), W'(8'h00));
    check("reset unlocked", W'(cfg_unlocked), W'(1'b0));

    rd(ID, v);            check("id read", W'(v), W'(8'h21));

    // Shadow write while locked is dropped and flags err.
    wr(3, 8'h5C);
    rd(STAT, v);          check("status err", W'(v), W'(8'h04));
    rd(STAT, v);          check("status err cleared", W'(v), W'(8'h00));
    rd(3, v);             check("locked shadow unchanged", W'(v), W'(8'h00));

    // Unlock, write, commit.
    wr(KEY, 8'hA5);
    wr(3, 8'h5C);
    wr(CTRL, 8'h01);
    check("upd before copy", W'(cfg_upd), W'(1'b0));
    @(negedge clk_sys);
    check("upd pulse", W'(cfg_upd), W'(1'b1));
    check("commit reg3", W'(cfg_out[31:24]), W'(8'h5C));
    @(negedge clk_sys);
    check("upd one cycle", W'(cfg_upd), W'(1'b0));
    rd(STAT, v);          check("status after commit", W'(v), W'(8'h01));
    rd(ACT0 + 3, v);      check("active3 read", W'(v), W'(8'h5C));

    // Discard.
    wr(KEY, 8'hA5);
    wr(0, 8'hFF);
    rd(STAT, v);          check("status pending", W'(v), W'(8'h03));
    wr(CTRL, 8'h02);
    rd(0, v);             check("discard shadow0", W'(v), W'(8'h00));
    rd(STAT, v);          check("status after discard", W'(v), W'(8'h01));

    // Read-only / out-of-range / aliased writes, boundary register, commit+discard.
    wr(KEY, 8'hA5);
    wr(STAT, 8'hFF);
    wr(2*NREG + 4, 8'hEE);
    wra(AW'(BASE - 1), 8'hEE);
    wra(AW'(BASE + (1 << 20) + 3), 8'hEE);
    wr(NREG - 1, 8'h77);
    wr(1, 8'h11);
    rd(2*NREG + 4, v);    check("oob read", W'(v), W'(8'h00));
    rd(CTRL, v);          check("ctrl read", W'(v), W'(8'h00));
    rd(KEY, v);           check("key read", W'(v), W'(8'h00));
    rda(AW'(BASE - 1), v); check("below base read", W'(v), W'(8'h00));
    wr(CTRL, 8'h03);
    repeat (2) @(negedge clk_sys);
    check("commit last reg", W'(cfg_out[W-1:W-8]), W'(8'h77));
    check("commit reg1", W'(cfg_out[15:8]), W'(8'h11));
    check("alias no effect", W'(cfg_out[31:24]), W'(8'h5C));
    rd(STAT, v);          check("no err from ignored", W'(v), W'(8'h01));

    // Write during commit cycle, and same-cycle read/write.
    wr(KEY, 8'hA5);
    wr(2, 8'h22);
    wr(CTRL, 8'h01);
    wr(2, 8'h33);
    @(negedge clk_sys);
    rd(ACT0 + 2, v);      check("commit took old shadow", W'(v), W'(8'h22));
    rd(2, v);             check("late write kept", W'(v), W'(8'h33));
    fx_wr = 1'b1; fx_waddr = AW'(BASE + 2); fx_data = 8'h44;
    fx_rd = 1'b1; fx_raddr = AW'(BASE + 2);
    @(negedge clk_sys);
    fx_wr = 1'b0; fx_rd = 1'b0;
    check("rd/wr same reg", W'(fx_q), W'(8'h33));
    rd(2, v);             check("rd after wr", W'(v), W'(8'h44));
    rd(STAT, v);          check("status pending2", W'(v), W'(8'h03));

    // Idle relock.
    wr(KEY, 8'hA5);
    repeat (7) @(negedge clk_sys);
    check("still unlocked", W'(cfg_unlocked), W'(1'b1));
    @(negedge clk_sys);
    check("auto relock", W'(cfg_unlocked), W'(1'b0));
    wr(5, 8'h55);
    rd(STAT, v);          check("relock err", W'(v), W'(8'h06));
    rd(5, v);             check("relock write dropped", W'(v), W'(8'h00));

    // Reset during the commit cycle.
    wr(KEY, 8'hA5);
    wr(4, 8'h9A);
    wr(CTRL, 8'h01);
    rst_n = 1'b0;
    #1 check("async reset cfg_out", cfg_out, '0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("abort no upd", W'(cfg_upd), W'(1'b0));
    check("abort locked", W'(cfg_unlocked), W'(1'b0));
    check("abort cfg_out", cfg_out, '0);
    @(negedge clk_sys);
    check("abort no upd later", W'(cfg_upd), W'(1'b0));
    rd(4, v);             check("shadow reset", W'(v), W'(8'h00));
    rd(STAT, v);          check("status after reset", W'(v), W'(8'h00));
    rd(ID, v);            check("id again", W'(v), W'(8'h21));

    @(negedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/ctrl_reg_bank.md
CTRL_REG_BANK -- requirements
Module: ctrl_reg_bank

Interface
REQ-001 SHALL have parameter AW, default 22: fx address width.
REQ-002 SHALL have parameter NREG, default 16: number of 8-bit config registers, legal 1..64.
REQ-003 SHALL have parameter BASE, default 22'h000100: byte address of register 0.
REQ-004 SHALL have parameter RST_VAL, default all zeros: NREG*8-bit reset image, register i at bits [8i+7:8i].
REQ-005 SHALL have parameter LOCK_TO, default 65535: idle cycles before auto-relock, legal 1..65535.
REQ-006 SHALL have parameter VERSION, default 8'h21: ID register value.
REQ-007 clk_sys  input  1  system clock, all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 fx_waddr  input  AW  write byte address.
REQ-010 fx_wr  input  1  write strobe, one write per high cycle.
REQ-011 fx_data  input  8  write data.
REQ-012 fx_rd  input  1  read strobe, one read per high cycle.
REQ-013 fx_raddr  input  AW  read byte address.
REQ-014 fx_q  output  8  registered read data.
REQ-015 cfg_out  output  NREG*8  active (committed) register image.
REQ-016 cfg_upd  output  1  one-cycle pulse when cfg_out changes.
REQ-017 cfg_unlocked  output  1  high while bank is in UNLOCKED.

Function
REQ-018 Offsets (addr-BASE): 0..NREG-1 SHADOW[i] R/W; NREG CTRL W; NREG+1 KEY W; NREG+2 STATUS R; NREG+3 ID R; NREG+4..2*NREG+3 ACTIVE[i] R.
REQ-019 State machine SHALL have states LOCKED, UNLOCKED, COMMIT.
REQ-020 KEY write of 8'hA5 SHALL move to UNLOCKED; KEY write of any other value SHALL move to LOCKED.
REQ-021 In UNLOCKED, a SHADOW write SHALL update SHADOW[i] on the next edge; in LOCKED, SHADOW writes SHALL be ignored and set STATUS.err.
REQ-022 CTRL write with bit0=1 in UNLOCKED SHALL enter COMMIT for exactly one cycle, copy all SHADOW to ACTIVE at end of that cycle, and pulse cfg_upd in the following cycle, then return to UNLOCKED.
REQ-023 CTRL write with bit1=1 (discard) SHALL reload SHADOW from ACTIVE in one cycle, no cfg_upd; bit0 and bit1 both set: commit wins.
REQ-024 CTRL write while LOCKED SHALL be ignored and set STATUS.err.
REQ-025 Idle counter SHALL reset on every accepted fx_wr in UNLOCKED; on reaching LOCK_TO without a write it SHALL force LOCKED.
REQ-026 STATUS = {5'b0, err, pending, unlocked}; pending = (SHADOW != ACTIVE); err sticky, cleared by STATUS read (the read returns err=1).
REQ-027 fx_q SHALL update one cycle after fx_rd high, hold value otherwise; write-only or out-of-range offsets read 8'h00.
REQ-028 Simultaneous fx_wr and fx_rd to same register: read SHALL return pre-write value.
REQ-029 Writes to read-only or out-of-range offsets SHALL be ignored with no side effects.
REQ-030 fx_wr during COMMIT SHALL be applied after the copy (new shadow value not committed).
REQ-031 Address comparison SHALL use full AW bits; no aliasing.

Reset
REQ-032 On rst_n low, asynchronously: SHADOW=ACTIVE=RST_VAL, fx_q=0, cfg_upd=0, state LOCKED, err=0, idle counter 0.
REQ-033 Reset asserted during COMMIT SHALL abort it: ACTIVE=RST_VAL, no cfg_upd after release.

Verification
REQ-034 Reset, read ID (BASE+NREG+3) -> fx_q=8'h21 one cycle after fx_rd; cfg_out=0.
REQ-035 Write SHADOW[3]=8'h5C while LOCKED -> SHADOW unchanged; STATUS read = 8'h04, second read = 8'h00.
REQ-036 KEY=8'hA5, SHADOW[3]=8'h5C, CTRL=8'h01 -> cfg_out[31:24]=8'h5C, cfg_upd high exactly one cycle, STATUS=8'h01.
REQ-037 Unlock, SHADOW[0]=8'hFF, CTRL=8'h02 -> SHADOW[0] reads 8'h00, pending=0, no cfg_upd.
REQ-038 LOCK_TO=8: unlock, idle 8 cycles -> cfg_unlocked falls; subsequent SHADOW write ignored, err set.
REQ-039 rst_n pulse low during COMMIT cycle -> cfg_out=RST_VAL, cfg_upd stays 0, state LOCKED.
